// File: rtl/store_narrow.sv
// Store-path narrowing unit: aligns byte/half/word stores onto a little-endian
// 32-bit bus with byte enables, then runs a req/ack handshake with a timeout.
module store_narrow #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_size,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  output logic        done,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic        lossy
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [1:0] CODE_MISALIGNED = 2'b01;
  localparam logic [1:0] CODE_BAD_SIZE   = 2'b10;
  localparam logic [1:0] CODE_TIMEOUT    = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    REQ   = 2'b01,
    DONE  = 2'b10,
    FAULT = 2'b11
  } state_t;

  state_t        state;
  logic [CW-1:0] count;

  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic        lossy_next;
  logic        misaligned;
  logic        bad_size;

  // Lane placement and truncation-loss detection for the request on the bus now.
  always_comb begin
    be_next    = 4'b0000;
    wdata_next = 32'h0000_0000;
    lossy_next = 1'b0;
    misaligned = 1'b0;
    bad_size   = 1'b0;
    case (st_size)
      SIZE_BYTE: begin
        be_next    = 4'b0001 << st_addr[1:0];
        wdata_next = {24'h00_0000, st_data[7:0]} << {st_addr[1:0], 3'b000};
        lossy_next = (st_data[31:8] != {24{st_data[7]}});
      end
      SIZE_HALF: begin
        be_next    = st_addr[1] ? 4'b1100 : 4'b0011;
        wdata_next = {16'h0000, st_data[15:0]} << {st_addr[1], 4'b0000};
        lossy_next = (st_data[31:16] != {16{st_data[15]}});
        misaligned = st_addr[0];
      end
      SIZE_WORD: begin
        be_next    = 4'b1111;
        wdata_next = st_data;
        misaligned = (st_addr[1:0] != 2'b00);
      end
      default: begin
        bad_size = 1'b1;
      end
    endcase
  end

  assign st_ready = (state == IDLE);

  // Control FSM; done/fault are single-cycle pulses, fault_code persists.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      count      <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= 32'h0000_0000;
      mem_wdata  <= 32'h0000_0000;
      mem_be     <= 4'b0000;
      done       <= 1'b0;
      fault      <= 1'b0;
      fault_code <= 2'b00;
      lossy      <= 1'b0;
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
      case (state)
        IDLE: begin
          if (st_valid) begin
            lossy <= lossy_next;
            if (bad_size) begin
              fault      <= 1'b1;
              fault_code <= CODE_BAD_SIZE;
              state      <= FAULT;
            end else if (misaligned) begin
              fault      <= 1'b1;
              fault_code <= CODE_MISALIGNED;
              state      <= FAULT;
            end else begin
              mem_addr  <= {st_addr[31:2], 2'b00};
              mem_wdata <= wdata_next;
              mem_be    <= be_next;
              mem_req   <= 1'b1;
              count     <= '0;
              state     <= REQ;
            end
          end
        end
        REQ: begin
          // An ack on the final allowed cycle still completes the store.
          if (mem_ack) begin
            mem_req <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else if (count == LAST) begin
            mem_req    <= 1'b0;
            fault      <= 1'b1;
            fault_code <= CODE_TIMEOUT;
            state      <= FAULT;
          end else begin
            count <= count + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        FAULT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_narrow.sv
// Directed bench for store_narrow with TIMEOUT=4; all expectations are hand-computed.
module tb_store_narrow;

  logic        clk;
  logic        reset_n;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        done;
  logic        fault;
  logic [1:0]  fault_code;
  logic        lossy;

  int checks;
  int errors;
  int req_cycles;

  store_narrow #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .st_valid   (st_valid),
    .st_ready   (st_ready),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .st_size    (st_size),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_ack    (mem_ack),
    .done       (done),
    .fault      (fault),
    .fault_code (fault_code),
    .lossy      (lossy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] addr,
                               input logic [31:0] data, input logic [1:0] size);
    st_valid = valid;
    st_addr  = addr;
    st_data  = data;
    st_size  = size;
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset_n  = 1'b0;
    mem_ack  = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00);
    repeat (2) @(negedge clk);

    checkOutput("rst_ready", 32'(st_ready), 1);
    checkOutput("rst_req", 32'(mem_req), 0);
    checkOutput("rst_addr", mem_addr, 32'h0);
    checkOutput("rst_wdata", mem_wdata, 32'h0);
    checkOutput("rst_be", 32'(mem_be), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_fault", 32'(fault), 0);
    checkOutput("rst_code", 32'(fault_code), 0);
    checkOutput("rst_lossy", 32'(lossy), 0);
    reset_n = 1'b1;
    tick();

    // Byte store to lane 3, ack sampled at edge 2
    $display("[TB] byte store lane 3");
    applyStimulus(1'b1, 32'h0000_1003, 32'hFFFF_FF80, 2'b00);
    tick();
    st_valid = 1'b0;
    checkOutput("b3_req", 32'(mem_req), 1);
    checkOutput("b3_ready", 32'(st_ready), 0);
    checkOutput("b3_addr", mem_addr, 32'h0000_1000);
    checkOutput("b3_be", 32'(mem_be), 32'h8);
    checkOutput("b3_wdata", mem_wdata, 32'h8000_0000);
    checkOutput("b3_lossy", 32'(lossy), 0);
    tick();
    checkOutput("b3_req_hold", 32'(mem_req), 1);
    checkOutput("b3_no_done", 32'(done), 0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checkOutput("b3_done", 32'(done), 1);
    checkOutput("b3_req_drop", 32'(mem_req), 0);
    tick();
    checkOutput("b3_done_pulse", 32'(done), 0);
    checkOutput("b3_ready_back", 32'(st_ready), 1);

    // Half store to upper lanes with immediate ack; ack in IDLE is ignored
    $display("[TB] half store upper, lossy");
    applyStimulus(1'b1, 32'h0000_2002, 32'h0001_2345, 2'b01);
    mem_ack = 1'b1;
    tick();
    st_valid = 1'b0;
    checkOutput("h2_req", 32'(mem_req), 1);
    checkOutput("h2_done_early", 32'(done), 0);
    checkOutput("h2_be", 32'(mem_be), 32'hC);
    checkOutput("h2_wdata", mem_wdata, 32'h2345_0000);
    checkOutput("h2_lossy", 32'(lossy), 1);
    tick();
    mem_ack = 1'b0;
    checkOutput("h2_done", 32'(done), 1);
    checkOutput("h2_ready_c2", 32'(st_ready), 0);
    tick();
    checkOutput("h2_ready_c3", 32'(st_ready), 1);

    // Byte store to lane 1, lossy because 0xAB does not sign-extend to 0x000000AB
    $display("[TB] byte store lane 1");
    applyStimulus(1'b1, 32'h0000_5001, 32'h0000_00AB, 2'b00);
    mem_ack = 1'b1;
    tick();
    st_valid = 1'b0;
    checkOutput("b1_addr", mem_addr, 32'h0000_5000);
    checkOutput("b1_be", 32'(mem_be), 32'h2);
    checkOutput("b1_wdata", mem_wdata, 32'h0000_AB00);
    checkOutput("b1_lossy", 32'(lossy), 1);
    tick();
    mem_ack = 1'b0;
    checkOutput("b1_done", 32'(done), 1);
    tick();

    // Misaligned word
    $display("[TB] misaligned word");
    applyStimulus(1'b1, 32'h0000_1001, 32'h1234_5678, 2'b10);
    tick();
    st_valid = 1'b0;
    checkOutput("mw_fault", 32'(fault), 1);
    checkOutput("mw_code", 32'(fault_code), 1);
    checkOutput("mw_req", 32'(mem_req), 0);
    checkOutput("mw_done", 32'(done), 0);
    checkOutput("mw_lossy", 32'(lossy), 0);
    checkOutput("mw_ready_c1", 32'(st_ready), 0);
    tick();
    checkOutput("mw_fault_pulse", 32'(fault), 0);
    checkOutput("mw_ready_c2", 32'(st_ready), 1);
    checkOutput("mw_code_hold", 32'(fault_code), 1);
    checkOutput("mw_req_never", 32'(mem_req), 0);

    // Misaligned half still records lossy
    $display("[TB] misaligned half");
    applyStimulus(1'b1, 32'h0000_0001, 32'h0000_8000, 2'b01);
    tick();
    st_valid = 1'b0;
    checkOutput("mh_fault", 32'(fault), 1);
    checkOutput("mh_code", 32'(fault_code), 1);
    checkOutput("mh_lossy", 32'(lossy), 1);
    tick();

    // Reserved size
    $display("[TB] reserved size");
    applyStimulus(1'b1, 32'h0000_0000, 32'h1234_5678, 2'b11);
    tick();
    st_valid = 1'b0;
    checkOutput("rs_fault", 32'(fault), 1);
    checkOutput("rs_code", 32'(fault_code), 2);
    checkOutput("rs_lossy", 32'(lossy), 0);
    checkOutput("rs_req", 32'(mem_req), 0);
    tick();

    // Timeout: no ack, mem_req held exactly TIMEOUT=4 cycles
    $display("[TB] timeout");
    applyStimulus(1'b1, 32'h0000_3000, 32'hCAFE_BABE, 2'b10);
    tick();
    st_valid = 1'b0;
    req_cycles = 0;
    for (int i = 0; i < 10 && mem_req; i++) begin
      req_cycles++;
      tick();
    end
    checkOutput("to_req_cycles", 32'(req_cycles), 4);
    checkOutput("to_fault", 32'(fault), 1);
    checkOutput("to_code", 32'(fault_code), 3);
    checkOutput("to_done", 32'(done), 0);
    tick();
    checkOutput("to_ready", 32'(st_ready), 1);

    // Ack on the 4th REQ cycle wins over the timeout
    $display("[TB] ack on last cycle");
    applyStimulus(1'b1, 32'h0000_3004, 32'h0000_0042, 2'b10);
    tick();
    st_valid = 1'b0;
    repeat (3) tick();
    checkOutput("al_req_c4", 32'(mem_req), 1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checkOutput("al_done", 32'(done), 1);
    checkOutput("al_fault", 32'(fault), 0);
    checkOutput("al_code_keep", 32'(fault_code), 3);
    tick();

    // Back-to-back words with st_valid held high
    $display("[TB] back-to-back");
    applyStimulus(1'b1, 32'h0000_4000, 32'h1111_1111, 2'b10);
    tick();
    checkOutput("bb1_wdata", mem_wdata, 32'h1111_1111);
    checkOutput("bb1_be", 32'(mem_be), 32'hF);
    applyStimulus(1'b1, 32'h0000_4004, 32'h2222_2222, 2'b10);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checkOutput("bb1_done", 32'(done), 1);
    checkOutput("bb1_addr_hold", mem_addr, 32'h0000_4000);
    checkOutput("bb_not_ready", 32'(st_ready), 0);
    tick();
    checkOutput("bb_ready", 32'(st_ready), 1);
    tick();
    st_valid = 1'b0;
    checkOutput("bb2_req", 32'(mem_req), 1);
    checkOutput("bb2_addr", mem_addr, 32'h0000_4004);
    checkOutput("bb2_wdata", mem_wdata, 32'h2222_2222);
    checkOutput("bb2_be", 32'(mem_be), 32'hF);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checkOutput("bb2_done", 32'(done), 1);
    tick();

    // Asynchronous reset during REQ
    $display("[TB] reset during REQ");
    applyStimulus(1'b1, 32'h0000_6000, 32'h0000_0180, 2'b00);
    tick();
    st_valid = 1'b0;
    checkOutput("ar_req_pre", 32'(mem_req), 1);
    checkOutput("ar_lossy_pre", 32'(lossy), 1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("ar_req", 32'(mem_req), 0);
    checkOutput("ar_be", 32'(mem_be), 0);
    checkOutput("ar_lossy", 32'(lossy), 0);
    checkOutput("ar_done", 32'(done), 0);
    checkOutput("ar_fault", 32'(fault), 0);
    @(negedge clk);
    reset_n = 1'b1;
    checkOutput("ar_ready", 32'(st_ready), 1);
    applyStimulus(1'b1, 32'h0000_7000, 32'h0BAD_F00D, 2'b10);
    tick();
    st_valid = 1'b0;
    checkOutput("ar_new_wdata", mem_wdata, 32'h0BAD_F00D);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checkOutput("ar_new_done", 32'(done), 1);
    checkOutput("ar_new_fault", 32'(fault), 0);
    tick();
    checkOutput("ar_new_ready", 32'(st_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_narrow.md
# store_narrow

Store-path narrowing unit for the processor datapath: the write-side counterpart of the load-path 16→32 sign extension. It accepts a 32-bit register value with an address and access size (byte/half/word), and checks alignment and size. It narrows and lane-shifts the data onto a little-endian 32-bit memory bus with byte enables, then runs a request/acknowledge handshake with a timeout. It flags stores whose truncation loses information, meaning the narrowed value would not sign-extend back to the original register value.

## Interface
- TIMEOUT, 15, number of consecutive mem_req cycles without mem_ack before a timeout fault (≥1)
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- st_valid  in  1  store request valid
- st_ready  out  1  unit can accept a request (high only in IDLE)
- st_addr  in  32  byte address
- st_data  in  32  register value to store
- st_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- mem_req  out  1  memory write request, held until ack or timeout
- mem_addr  out  32  word-aligned address {st_addr[31:2],2'b00}
- mem_wdata  out  32  lane-shifted write data, unused lanes zero
- mem_be  out  4  byte enables, bit k = byte lane k (bits [8k+7:8k])
- mem_ack  in  1  memory accepted the write; sampled only in REQ
- done  out  1  one-cycle pulse on successful completion
- fault  out  1  one-cycle pulse on rejected or timed-out store
- fault_code  out  2  00 none, 01 misaligned, 10 bad size, 11 timeout; held until next fault or reset
- lossy  out  1  truncation-loss flag of the last accepted store

## Operation
- States: IDLE, REQ, DONE, FAULT. Reset → IDLE.
- st_ready = (state==IDLE). A transfer occurs on st_valid && st_ready at a rising edge.
- On transfer, checks are applied in this order:
  - size==11 → FAULT, code 10.
  - half with addr[0]≠0, or word with addr[1:0]≠00 → FAULT, code 01.
  - Otherwise register mem_addr/mem_wdata/mem_be and go to REQ.
- Byte, k=addr[1:0]: be = 1<<k; wdata = st_data[7:0]<<(8k).
- Half: be = addr[1] ? 1100 : 0011; wdata = st_data[15:0]<<(16·addr[1]).
- Word: be = 1111; wdata = st_data.
- lossy is registered on every transfer, faulting ones included:
  - byte: st_data[31:8] ≠ {24{st_data[7]}}
  - half: st_data[31:16] ≠ {16{st_data[15]}}
  - word or reserved: 0
- lossy is informational only; the store proceeds regardless.
- REQ: mem_req=1 and mem_addr/wdata/be are stable.
  - mem_ack → DONE.
  - Otherwise the cycle counter increments; when it reaches TIMEOUT-1 without ack → FAULT, code 11.
  - Counter width is clog2(TIMEOUT+1); it clears on entry to REQ.
- DONE: done=1, mem_req=0 → IDLE.
- FAULT: fault=1, mem_req=0, no memory access is issued for size/alignment faults → IDLE.
- mem_addr/wdata/be hold their last values outside REQ; their contents are don't-care when mem_req=0.

## Timing
- Reset values (asserted asynchronously):
  - state IDLE, st_ready 1, mem_req 0
  - mem_addr/mem_wdata 0, mem_be 0000
  - done 0, fault 0, fault_code 00, lossy 0, counter 0
- Successful store: transfer at edge 0; mem_req high from cycle 1. If ack is first sampled at edge n (n≥1), done is high in cycle n+1 and st_ready returns in cycle n+2. Minimum 3 cycles per store.
- Size/alignment fault: transfer at edge 0, fault high in cycle 1, st_ready in cycle 2; mem_req never rises.
- Timeout: mem_req is high for exactly TIMEOUT cycles, then fault is high for one cycle.
- Ack in the same cycle the counter hits TIMEOUT-1: ack wins → DONE, no fault.
- mem_ack outside REQ is ignored. st_valid while st_ready=0 is ignored; the requester must hold it.
- done and fault are never high together.
- reset_n low mid-REQ: mem_req drops immediately (asynchronously) and the in-flight store is abandoned with no done or fault.

## Test plan
- Byte store, addr 0x00001003, data 0xFFFFFF80 → mem_addr 0x00001000, be 1000, wdata 0x80000000, lossy 0; ack after 2 cycles → done pulse one cycle after ack.
- Half store, addr 0x00002002, data 0x00012345 → be 1100, wdata 0x23450000, lossy 1; immediate ack → done in cycle 2, st_ready in cycle 3.
- Word store at 0x00001001 → fault in cycle 1, code 01, mem_req stays 0. Size 11 at 0x0 → code 10.
- TIMEOUT=4, no ack → mem_req high exactly 4 cycles, fault with code 11. Repeat with ack on the 4th cycle → done, no fault, fault_code unchanged.
- Back-to-back: st_valid held high for two word stores → second transfer only when st_ready returns, with correct be/wdata for each.
- Assert reset_n low during REQ → mem_req, done, fault, be, lossy go to 0 at once; after release st_ready=1 and a new store completes normally.
